// File: rtl/acc_cpu_gen2.sv
// acc_cpu_gen2: parametrised single-cycle accumulator CPU.
// One instruction retires per cycle from a combinational instruction memory,
// with a fetch stall input, a carry flag, HALT/resume, a return stack, and
// sticky stack faults that stay in place until isReset.
module acc_cpu_gen2 #(
  parameter int DATA_WIDTH   = 16,
  parameter int PC_WIDTH     = 8,
  parameter int INSTR_WIDTH  = 16,
  parameter int NUM_REGS     = 8,
  parameter int STACK_DEPTH  = 16,
  parameter int SWITCH_WIDTH = 1
) (
  input  logic                               clock,
  input  logic                               isReset,
  input  logic [INSTR_WIDTH-1:0]             instruction,
  input  logic                               instrValid,
  input  logic [SWITCH_WIDTH-1:0]            switch,
  input  logic                               resume,
  output logic [PC_WIDTH-1:0]                pc,
  output logic [DATA_WIDTH-1:0]              accumulator,
  output logic [3:0]                         opCode,
  output logic [DATA_WIDTH-1:0]              register1Value,
  output logic                               carry,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stackDepth,
  output logic [1:0]                         cpuState,
  output logic [1:0]                         faultCode
);

  localparam int RSEL  = $clog2(NUM_REGS);
  localparam int SD_W  = $clog2(STACK_DEPTH + 1);
  localparam int SP_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int IMM_W = INSTR_WIDTH - 4;
  localparam logic [SD_W-1:0] DEPTH_FULL = SD_W'(STACK_DEPTH);

  typedef enum logic [3:0] {
    OP_LOAD    = 4'd0,  OP_MOVE    = 4'd1,  OP_ADD     = 4'd2,  OP_JUMP    = 4'd3,
    OP_RESET   = 4'd4,  OP_IF0JUMP = 4'd5,  OP_IF1JUMP = 4'd6,  OP_LOADSW  = 4'd7,
    OP_CALL    = 4'd8,  OP_EXIT    = 4'd9,  OP_LOADREG = 4'd10, OP_INC     = 4'd11,
    OP_COPY    = 4'd12, OP_LSHIFT  = 4'd13, OP_SUB     = 4'd14, OP_HALT    = 4'd15
  } op_e;

  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_HALT = 2'd1, ST_FAULT = 2'd2} state_e;
  typedef enum logic [1:0] {FC_NONE = 2'd0, FC_OVERFLOW = 2'd1, FC_UNDERFLOW = 2'd2} fault_e;

  // Architectural state
  state_e                  state_q, state_d;
  fault_e                  fault_q, fault_d;
  logic [PC_WIDTH-1:0]     pc_q, pc_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic                    carry_q, carry_d;
  logic [SD_W-1:0]         depth_q, depth_d;
  logic [DATA_WIDTH-1:0]   regs_q  [NUM_REGS];
  logic [PC_WIDTH-1:0]     stack_q [2**SP_W];

  // Decoded fields
  op_e                     op;
  logic [RSEL-1:0]         ra, rb;
  logic [DATA_WIDTH-1:0]   imm, sw_ext, ra_val;
  logic [PC_WIDTH-1:0]     target, pc_inc;
  logic [SP_W-1:0]         push_idx, pop_idx;

  // Execute qualifiers
  logic exec, call_ovf, exit_unf, retire;

  // Register-file write port and stack push
  logic                    reg_we;
  logic [RSEL-1:0]         reg_waddr;
  logic [DATA_WIDTH-1:0]   reg_wdata;
  logic                    push;

  assign op     = op_e'(instruction[INSTR_WIDTH-1 -: 4]);
  assign ra     = instruction[8 +: RSEL];
  assign rb     = instruction[4 +: RSEL];
  assign target = instruction[PC_WIDTH-1:0];
  assign pc_inc = pc_q + 1'b1;
  assign ra_val = regs_q[ra];

  // The entry being pushed sits at index depth; the top of stack is depth-1.
  assign push_idx = SP_W'(depth_q);
  assign pop_idx  = SP_W'(depth_q - 1'b1);

  if (IMM_W >= DATA_WIDTH) begin : g_imm_trunc
    assign imm = instruction[DATA_WIDTH-1:0];
  end else begin : g_imm_ext
    assign imm = {{(DATA_WIDTH-IMM_W){1'b0}}, instruction[IMM_W-1:0]};
  end

  if (SWITCH_WIDTH >= DATA_WIDTH) begin : g_sw_trunc
    assign sw_ext = switch[DATA_WIDTH-1:0];
  end else begin : g_sw_ext
    assign sw_ext = {{(DATA_WIDTH-SWITCH_WIDTH){1'b0}}, switch};
  end

  // A fault attempt is treated as "no retire": nothing architectural moves,
  // only the FSM records the fault.
  assign exec     = (state_q == ST_RUN) && instrValid;
  assign call_ovf = exec && (op == OP_CALL) && (depth_q == DEPTH_FULL);
  assign exit_unf = exec && (op == OP_EXIT) && (depth_q == '0);
  assign retire   = exec && !call_ovf && !exit_unf;

  // Datapath next-state: effect of the retiring instruction
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; an unassigned path in combinational logic infers a latch.
    pc_d      = pc_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    depth_d   = depth_q;
    reg_we    = 1'b0;
    reg_waddr = ra;
    reg_wdata = acc_q;
    push      = 1'b0;
    if (retire) begin
      pc_d = pc_inc;
      case (op)
        OP_LOAD:    acc_d = imm;
        OP_MOVE:    reg_we = 1'b1;
        OP_ADD:     {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, ra_val};
        OP_JUMP:    pc_d = target;
        OP_RESET: begin
          pc_d    = '0;
          acc_d   = '0;
          carry_d = 1'b0;
          depth_d = '0;
        end
        OP_IF0JUMP: if (acc_q == '0) pc_d = target;
        OP_IF1JUMP: if (acc_q != '0) pc_d = target;
        OP_LOADSW:  acc_d = sw_ext;
        OP_CALL: begin
          push    = 1'b1;
          depth_d = depth_q + 1'b1;
          pc_d    = target;
        end
        OP_EXIT: begin
          pc_d    = stack_q[pop_idx];
          depth_d = depth_q - 1'b1;
        end
        OP_LOADREG: acc_d = ra_val;
        OP_INC:     acc_d = acc_q + 1'b1;
        OP_COPY: begin
          reg_we    = 1'b1;
          reg_waddr = rb;
          reg_wdata = ra_val;
        end
        OP_LSHIFT: begin
          carry_d = acc_q[DATA_WIDTH-1];
          acc_d   = acc_q << 1;
        end
        OP_SUB:     {carry_d, acc_d} = {1'b0, acc_q} - {1'b0, ra_val};
        OP_HALT:    ;
      endcase
    end
  end

  // Datapath registers and register file, cleared by isReset
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (isReset) begin
      pc_q    <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      depth_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      depth_q <= depth_d;
      if (reg_we) regs_q[reg_waddr] <= reg_wdata;
    end
  end

  // Return-stack storage
  always_ff @(posedge clock) begin
    // NOTE: the register file is visible state and is cleared above; the
    // stack is only ever read below depth, so it has no reset and can map
    // onto plain storage.
    if (push) stack_q[push_idx] <= pc_inc;
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (isReset) begin
      state_q <= ST_RUN;
      fault_q <= FC_NONE;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  // FSM next state: HALT waits for resume, FAULT only leaves through isReset
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    case (state_q)
      ST_RUN: begin
        if (call_ovf) begin
          state_d = ST_FAULT;
          fault_d = FC_OVERFLOW;
        end else if (exit_unf) begin
          state_d = ST_FAULT;
          fault_d = FC_UNDERFLOW;
        end else if (retire && (op == OP_HALT)) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT:  if (resume) state_d = ST_RUN;
      ST_FAULT: ;
      default:  state_d = ST_FAULT;
    endcase
  end

  // FSM outputs
  always_comb begin
    cpuState  = state_q;
    faultCode = fault_q;
  end

  assign pc             = pc_q;
  assign accumulator    = acc_q;
  assign opCode         = instruction[INSTR_WIDTH-1 -: 4];
  assign register1Value = regs_q[RSEL'(1)];
  assign carry          = carry_q;
  assign stackDepth     = depth_q;

endmodule
